// File: rtl/mac_loop_counter.sv
// mac_loop_counter: multi-channel presettable up/down counter bank used for
// MAC loop and address sequencing. Each channel has its own modulus limit and
// registered terminal-count pulse; the sequencer addresses one channel per
// cycle through ch_sel.
//
// Optional feature macro: MAC_CNT_SAT_EN
//   defined   -> limit_sat port exists; each channel stores a mode bit
//                (1 = saturate at the limit / at zero, 0 = wrap).
//   undefined -> no limit_sat port, every channel wraps.

// Per-channel counter slice: count, limit and (optionally) mode registers.
module mac_loop_counter_ch #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sel,
  input  logic             load,
  input  logic             inc,
  input  logic             dec,
  input  logic [WIDTH-1:0] preset_val,
  input  logic             limit_wr,
  input  logic [WIDTH-1:0] limit_val,
`ifdef MAC_CNT_SAT_EN
  input  logic             limit_sat,
`endif
  output logic [WIDTH-1:0] cnt,
  output logic             tc,
  output logic             tc_nxt
);

  logic [WIDTH-1:0] lim;
  logic [WIDTH-1:0] cnt_nxt;
  logic             sat_mode;

`ifdef MAC_CNT_SAT_EN
  logic mode;

  // Mode bit travels with the limit; reset returns every channel to wrap.
  always_ff @(posedge clk) begin
    if (rst)                  mode <= 1'b0;
    else if (sel && limit_wr) mode <= limit_sat;
  end

  assign sat_mode = mode;
`else
  assign sat_mode = 1'b0;
`endif

  // Next count and terminal-count decision; compares against the limit held
  // before this edge so a same-cycle limit write does not affect the command.
  always_comb begin
    cnt_nxt = cnt;
    tc_nxt  = 1'b0;
    if (sel && load) begin
      cnt_nxt = preset_val;
    end else if (sel && (inc ^ dec)) begin
      if (inc) begin
        if (cnt >= lim) begin
          tc_nxt  = 1'b1;
          // Saturate holds whatever is there, including a count loaded above limit.
          cnt_nxt = sat_mode ? cnt : '0;
        end else begin
          cnt_nxt = cnt + WIDTH'(1);
        end
      end else begin
        if (cnt == '0) begin
          tc_nxt  = 1'b1;
          cnt_nxt = sat_mode ? '0 : lim;
        end else begin
          cnt_nxt = cnt - WIDTH'(1);
        end
      end
    end
  end

  // Count, limit and tc registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      lim <= '1;
      tc  <= 1'b0;
    end else begin
      cnt <= cnt_nxt;
      tc  <= tc_nxt;
      if (sel && limit_wr) lim <= limit_val;
    end
  end

endmodule

// Top: fans the shared command out to NUM_CH slices; a channel whose index
// matches ch_sel acts, so out-of-range selects touch nothing.
module mac_loop_counter #(
  parameter  int WIDTH  = 8,
  parameter  int NUM_CH = 4,
  localparam int CHW    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [CHW-1:0]          ch_sel,
  input  logic                    load,
  input  logic                    inc,
  input  logic                    dec,
  input  logic [WIDTH-1:0]        preset_val,
  input  logic                    limit_wr,
  input  logic [WIDTH-1:0]        limit_val,
`ifdef MAC_CNT_SAT_EN
  input  logic                    limit_sat,
`endif
  output logic [NUM_CH*WIDTH-1:0] count_out,
  output logic [NUM_CH-1:0]       tc,
  output logic                    any_tc
);

  logic [NUM_CH-1:0][WIDTH-1:0] cnt;
  logic [NUM_CH-1:0]            tc_nxt;

  for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
    mac_loop_counter_ch #(.WIDTH(WIDTH)) u_ch (
      .clk        (clk),
      .rst        (rst),
      .sel        (ch_sel == CHW'(n)),
      .load       (load),
      .inc        (inc),
      .dec        (dec),
      .preset_val (preset_val),
      .limit_wr   (limit_wr),
      .limit_val  (limit_val),
`ifdef MAC_CNT_SAT_EN
      .limit_sat  (limit_sat),
`endif
      .cnt        (cnt[n]),
      .tc         (tc[n]),
      .tc_nxt     (tc_nxt[n])
    );
  end

  assign count_out = cnt;

  // any_tc registered from the same next-state terms so it aligns with tc.
  always_ff @(posedge clk) begin
    if (rst) any_tc <= 1'b0;
    else     any_tc <= |tc_nxt;
  end

endmodule

// File: doc/mac_loop_counter.md
# mac_loop_counter

Multi-channel presettable up/down counter bank for the MAC datapath's loop and address sequencing. Each of NUM_CH independent channels holds a WIDTH-bit count with its own programmable modulus limit. Channels wrap (or optionally saturate) at the limit and pulse a per-channel terminal-count flag. The block is a generalised successor of the single-channel increment/load counter and is driven by the ISA sequencer one channel per cycle.

## Interface
Parameters:
- WIDTH, 8, counter and limit width in bits (>=2)
- NUM_CH, 4, number of channels (>=1); CHW = max(1, clog2(NUM_CH))

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  reset, synchronous, active-high
- ch_sel  input  CHW  channel addressed by load/inc/dec/limit_wr; values >= NUM_CH are ignored (no state change)
- load  input  1  load preset_val into selected channel
- inc  input  1  count selected channel up by 1
- dec  input  1  count selected channel down by 1
- preset_val  input  WIDTH  load data
- limit_wr  input  1  write limit_val into selected channel's limit register
- limit_val  input  WIDTH  limit data
- limit_sat  input  1  mode bit written with limit_wr (present only with MAC_CNT_SAT_EN)
- count_out  output  NUM_CH*WIDTH  all counts, channel n at bits [n*WIDTH +: WIDTH]
- tc  output  NUM_CH  per-channel terminal-count pulse, registered
- any_tc  output  1  registered OR of all tc bits, same cycle as tc

## Operation
- Reset: all counts 0, all limits all-ones (2^WIDTH-1), all mode bits 0 (wrap), tc 0, any_tc 0.
- Per-cycle priority on selected channel: rst > load > (inc XOR dec). inc and dec both high = hold, no tc.
- load: count <= preset_val; no tc. Value above limit is accepted unclamped.
- inc: if count >= limit -> count <= 0 and tc pulses; else count + 1.
- dec: if count == 0 -> count <= limit and tc pulses; else count - 1.
- Unselected channels hold; tc bits of unselected channels are 0.
- limit_wr is independent of load/inc/dec: both apply in the same cycle; the count operation compares against the limit value held before that edge.
- limit_val 0: inc always yields 0 with tc every cycle; dec from 0 yields 0 with tc.
- Arithmetic is modulo 2^WIDTH internally; no carry out.

## Timing
- count_out updates on the edge that samples the command (1-cycle latency, registered outputs).
- tc[n] and any_tc are high for exactly the one cycle following the wrapping edge; back-to-back wraps give consecutive high cycles.
- New limit takes effect for commands sampled on the edge after limit_wr.
- rst asserted mid-sequence clears everything on that edge, overriding any command in the same cycle; tc is 0 the following cycle.

## Configuration
- MAC_CNT_SAT_EN defined: limit_sat port exists; per-channel mode bit written with limit_wr. Mode 1 = saturate: inc at count >= limit holds count at limit (a count loaded above limit is held unchanged); dec at 0 holds 0; tc pulses on each such blocked attempt. Mode 0 = wrap as above.
- MAC_CNT_SAT_EN undefined: no limit_sat port, no mode register; all channels wrap.

## Test plan
- Reset, then inc ch0 x256 with default limit 255 (WIDTH=8) -> count 255 after 255 incs, 0 after 256th, tc[0] and any_tc high exactly one cycle.
- limit_wr ch2 limit 5, load 3, dec x4 -> counts 2,1,0,5; tc[2] pulses only after the 0->5 step.
- Same cycle load=1, inc=1, ch1, preset 0x40 -> count 0x40, no tc; inc=dec=1 next cycle -> holds 0x40.
- limit_wr ch3 limit 4 and inc same cycle with count 4, old limit 255 -> count 5, no tc; next inc -> 0 with tc.
- ch_sel=NUM_CH (NUM_CH=3) with load/inc -> no count changes; rst during active inc stream -> all counts 0, limits 255, tc 0.
- With MAC_CNT_SAT_EN: ch0 limit 3 limit_sat 1, inc x5 -> 1,2,3,3,3 with tc on 4th and 5th incs; dec from 0 -> holds 0, tc pulses.
